operand_issue_stage: RTL and testbench
======================================

Name: operand_issue_stage

Overview:
- Multi-cycle decode/issue stage directly upstream of the 16-bit `ALU` (inputs `op_a`, `op_b`, `alu_func`; output `alu_out`).
- Accepts one 16-bit instruction through a valid/ready handshake and reads operands from an internal 8x16 register file.
- Selects `op_b` as either a register value or a sign-extended 8-bit immediate, then drives the ALU.
- Captures `alu_out` and writes the result back to the register file.

Parameters:
- `DATA_W`, 16, datapath and register width.
- `REG_N`, 8, number of registers; address width is log2(`REG_N`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  upstream instruction word is valid.
- `instr_ready`  out  1  stage can accept an instruction.
- `instr`  in  16  instruction word.
- `op_a`  out  16  ALU operand A (registered).
- `op_b`  out  16  ALU operand B (registered).
- `alu_func`  out  4  ALU function code (registered).
- `alu_out`  in  16  ALU combinational result.
- `wb_valid`  out  1  one-cycle write-back strobe.
- `wb_addr`  out  3  write-back register index.
- `wb_data`  out  16  write-back data.
- `halted`  out  1  HALT has executed.
- `dbg_addr`  in  3  debug read address.
- `dbg_data`  out  16  combinational read of R[`dbg_addr`].

Behaviour:
- Instruction format:
  - [15:12] opcode; [11:9] rd (destination and source A); [8] imm flag.
  - R-type (imm flag = 0): [7:5] rs, [4:0] ignored.
  - I-type (imm flag = 1): [7:0] imm8.
- Operand selection:
  - `op_a` = R[rd].
  - R-type: `op_b` = R[rs].
  - I-type: `op_b` = {{8{imm8[7]}}, imm8}.
- `alu_func` = opcode, passed through unchanged; the ALU alone defines result semantics.
- Special opcodes:
  - 0000 is NOP: no ALU issue, no write-back.
  - 1111 is HALT.
  - Every other opcode is issued and written back.
- States: IDLE, DECODE, EXEC, WB, HALT.
- Timing (N = cycle in which `instr_valid` and `instr_ready` are both high at the rising edge):
  - `instr_ready` = 1 only in IDLE; the instruction is latched at the end of N.
  - N+1 (DECODE): register file read. `op_a`/`op_b`/`alu_func` registered at end of cycle, valid from N+2. NOP goes to IDLE; HALT goes to HALT; otherwise goes to EXEC.
  - N+2 (EXEC): operands stable for the full cycle; `alu_out` is captured into the result register at end of cycle.
  - N+3 (WB): `wb_valid`=1, `wb_addr`=rd, `wb_data`=captured result; R[rd] written at end of cycle.
  - N+4: back to IDLE, `instr_ready`=1.
  - Throughput is 1 instruction per 4 cycles; a NOP re-enables ready at N+2.
- `op_a`, `op_b` and `alu_func` hold their last values outside DECODE updates.
- `wb_valid` is high in WB only. `wb_addr`/`wb_data` hold their last values afterwards.
- `instr_valid` is ignored whenever `instr_ready`=0; `instr` need not remain stable after acceptance.
- HALT state:
  - `halted`=1 from N+2 onward.
  - `instr_ready`=0 permanently.
  - Only `rst` exits the state.
- Register file:
  - All 8 registers are writable; R0 is not hardwired.
  - Single write port (WB). Two read ports plus the debug port.
  - No bypass is needed, because DECODE never overlaps WB.
- Reset (synchronous, active-high):
  - State goes to IDLE; all registers, `op_a`, `op_b`, `alu_func`, `wb_addr`, `wb_data` and the result register go to 0.
  - `wb_valid`=0, `halted`=0, `instr_ready`=0 while `rst`=1; `instr_ready`=1 in the first cycle after release.
  - Reset mid-operation (DECODE/EXEC/WB) aborts the instruction: no `wb_valid` pulse and no register write in that cycle.

Decomposition:
- Shared package `cpu_pkg`:
  - Opcode constants `OP_NOP`=4'b0000 and `OP_HALT`=4'b1111.
  - ALU function codes 4'b0010, 4'b0100, 4'b0110, 4'b1000, 4'b1010.
  - Field bit positions, `DATA_W`, and state encoding.
- One sub-module, `reg_file_8x16`:
  - Synchronous write with synchronous reset.
  - Asynchronous read ports A, B and debug.

Test Plan (bench ALU model: `alu_out` = `op_a` + `op_b`):
- Reset: hold `rst` 2 cycles → all outputs 0 and `dbg_data`=0 for all 8 addresses; `instr_ready`=1 in the first cycle after release.
- I-type sign extension: `instr`=0x2384 → at N+2 `op_a`=0x0000, `op_b`=0xFF84, `alu_func`=4'b0010; at N+3 `wb_valid`=1, `wb_addr`=1, `wb_data`=0xFF84; R1=0xFF84 afterwards.
- R-type: after the previous test, issue 0x2501 (R2=0x0001), then 0x4420 → `op_a`=0x0001, `op_b`=0xFF84, `alu_func`=4'b0100; R2=0xFF85.
- Back-to-back: hold `instr_valid` high with 0x2301 then 0x2501 → second accepted exactly 4 cycles after first; `instr_ready` low for 3 cycles between; exactly two `wb_valid` pulses.
- NOP/HALT:
  - 0x0000 → no `wb_valid`, `instr_ready`=1 at N+2.
  - 0xF000 → `halted`=1 from N+2 and `instr_ready` stays 0 for 20 cycles; `rst` clears both.
- Reset mid-op: accept 0x2301, assert `rst` at N+2 (EXEC) → no `wb_valid` pulse; R1=0x0000 after reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the operand issue stage: opcodes, ALU function codes,
// instruction field positions, FSM encoding and decode helpers.
package cpu_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_N   = 8;
  localparam int ADDR_W  = $clog2(REG_N);
  localparam int INSTR_W = 16;

  // Opcodes with stage-level meaning; every other opcode goes straight to the ALU
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // ALU function codes; the ALU alone defines what each one computes
  localparam logic [3:0] FN_C2 = 4'b0010;
  localparam logic [3:0] FN_C4 = 4'b0100;
  localparam logic [3:0] FN_C6 = 4'b0110;
  localparam logic [3:0] FN_C8 = 4'b1000;
  localparam logic [3:0] FN_CA = 4'b1010;

  // Instruction field bit positions
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 9;
  localparam int IMM_BIT = 8;
  localparam int RS_HI   = 7;
  localparam int RS_LO   = 5;
  localparam int IMM8_HI = 7;
  localparam int IMM8_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [3:0]        opc;
    logic [ADDR_W-1:0] rd;
    logic              imm;
    logic [ADDR_W-1:0] rs;
    logic [7:0]        imm8;
  } dec_t;

  function automatic dec_t decode(input logic [INSTR_W-1:0] w);
    dec_t d;
    d.opc  = w[OPC_HI:OPC_LO];
    d.rd   = w[RD_HI:RD_LO];
    d.imm  = w[IMM_BIT];
    d.rs   = w[RS_HI:RS_LO];
    d.imm8 = w[IMM8_HI:IMM8_LO];
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
    return {{(DATA_W-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/operand_issue_stage_if.sv
// Instruction handshake, ALU operand/result and write-back bus of the issue stage.
interface operand_issue_stage_if;
  import cpu_pkg::*;

  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_W-1:0]     instr;
  logic [DATA_W-1:0]      op_a;
  logic [DATA_W-1:0]      op_b;
  logic [3:0]             alu_func;
  logic [DATA_W-1:0]      alu_out;
  logic                   wb_valid;
  logic [ADDR_W-1:0]      wb_addr;
  logic [DATA_W-1:0]      wb_data;

  // Upstream/ALU side
  modport master (
    output instr_valid, instr, alu_out,
    input  instr_ready, op_a, op_b, alu_func, wb_valid, wb_addr, wb_data
  );

  // Issue stage side
  modport slave (
    input  instr_valid, instr, alu_out,
    output instr_ready, op_a, op_b, alu_func, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/operand_issue_stage_reg_file.sv
// Register file: one synchronous write port with synchronous reset,
// three asynchronous read ports (operand A, operand B, debug).
module reg_file_8x16 #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_N  = cpu_pkg::REG_N,
  localparam int AW    = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  logic [REG_N-1:0][DATA_W-1:0] regs;

  // Reset clears every register; otherwise the addressed register takes wdata
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else if (we) begin
      for (int i = 0; i < REG_N; i++)
        if (waddr == AW'(i)) regs[i] <= wdata;
    end
  end

  assign ra_data  = regs[ra_addr];
  assign rb_data  = regs[rb_addr];
  assign dbg_data = regs[dbg_addr];
endmodule

// File: rtl/operand_issue_stage.sv
// Multi-cycle decode/issue stage: IDLE -> DECODE -> EXEC -> WB, one instruction
// every four cycles. Reads operands, drives the external ALU, writes the result back.
module operand_issue_stage #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_N  = cpu_pkg::REG_N,
  localparam int AW    = $clog2(REG_N)
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_issue_stage_if.slave bus,
  output logic                 halted,
  input  logic [AW-1:0]        dbg_addr,
  output logic [DATA_W-1:0]    dbg_data
);
  import cpu_pkg::*;

  state_t                state;
  logic [INSTR_W-1:0]    ir;
  dec_t                  dec;
  logic [DATA_W-1:0]     rd_data;
  logic [DATA_W-1:0]     rs_data;
  logic [DATA_W-1:0]     op_a_q;
  logic [DATA_W-1:0]     op_b_q;
  logic [3:0]            func_q;
  logic [DATA_W-1:0]     result_q;
  logic [AW-1:0]         wb_addr_q;
  logic                  wb_vld_q;
  logic                  wb_we;
  logic                  accept;

  assign dec = decode(ir);

  // Ready is gated by rst so nothing is accepted while reset is held
  assign bus.instr_ready = (state == S_IDLE) && !rst;
  assign accept          = bus.instr_valid && bus.instr_ready;

  // A reset landing on the WB cycle suppresses both the strobe and the write
  assign wb_we        = wb_vld_q && !rst;
  assign bus.wb_valid = wb_we;
  assign bus.wb_addr  = wb_addr_q;
  assign bus.wb_data  = result_q;
  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign bus.alu_func = func_q;

  reg_file_8x16 #(.DATA_W(DATA_W), .REG_N(REG_N)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_we),
    .waddr    (wb_addr_q),
    .wdata    (result_q),
    .ra_addr  (dec.rd),
    .ra_data  (rd_data),
    .rb_addr  (dec.rs),
    .rb_data  (rs_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Issue FSM; all datapath outputs are registered here and hold between updates
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ir        <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      func_q    <= '0;
      result_q  <= '0;
      wb_addr_q <= '0;
      wb_vld_q  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      wb_vld_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            ir    <= bus.instr;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec.opc == OP_NOP) begin
            state <= S_IDLE;
          end else if (dec.opc == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            op_a_q <= rd_data;
            op_b_q <= dec.imm ? sext8(dec.imm8) : rs_data;
            func_q <= dec.opc;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q  <= bus.alu_out;
          wb_addr_q <= dec.rd;
          wb_vld_q  <= 1'b1;
          state     <= S_WB;
        end
        S_WB:    state <= S_IDLE;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_operand_issue_stage.sv
// Bench for operand_issue_stage with an adder standing in for the ALU.
// Expected write-backs go into a scoreboard queue; a monitor checks each wb_valid.
module tb_operand_issue_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halted;
  logic [2:0]  dbg_addr = 3'd0;
  logic [15:0] dbg_data;

  operand_issue_stage_if bus();

  operand_issue_stage dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .halted   (halted),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #10 clk = ~clk;

  assign bus.alu_out = bus.op_a + bus.op_b;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   wb_cnt = 0;
  int   w0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic dbg_chk(input int a, input logic [15:0] exp);
    dbg_addr = 3'(a);
    #1;
    chk($sformatf("dbg_R%0d", a), dbg_data, exp);
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                      input logic [2:0] addr, input logic [15:0] data);
    exp_t x;
    x.a = a; x.b = b; x.f = f; x.addr = addr; x.data = data;
    sb.push_back(x);
  endtask

  // Called at a negedge; returns at the negedge of cycle N+1 with valid dropped
  task automatic send(input logic [15:0] w);
    int n = 0;
    bus.instr_valid = 1'b1;
    bus.instr = w;
    #1;
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL accept_timeout: instr %h not accepted within 20 cycles", w);
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk); #1;
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL idle_timeout: instr_ready still %b after 20 cycles", bus.instr_ready);
    end
  endtask

  // Scoreboard monitor: every write-back strobe must match the oldest expectation
  always begin
    @(negedge clk);
    #2;
    if (bus.wb_valid === 1'b1) begin
      wb_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got addr %0d data %h expected no write-back",
                 bus.wb_addr, bus.wb_data);
      end else begin
        e = sb.pop_front();
        chk("wb_op_a",  bus.op_a, e.a);
        chk("wb_op_b",  bus.op_b, e.b);
        chk("wb_func",  16'(bus.alu_func), 16'(e.f));
        chk("wb_addr",  16'(bus.wb_addr), 16'(e.addr));
        chk("wb_data",  bus.wb_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;

    // Reset held for two edges
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready",    16'(bus.instr_ready), 16'd0);
    chk("rst_wb_valid", 16'(bus.wb_valid), 16'd0);
    chk("rst_halted",   16'(halted), 16'd0);
    chk("rst_op_a",     bus.op_a, 16'h0000);
    chk("rst_op_b",     bus.op_b, 16'h0000);
    chk("rst_func",     16'(bus.alu_func), 16'd0);
    chk("rst_wb_addr",  16'(bus.wb_addr), 16'd0);
    chk("rst_wb_data",  bus.wb_data, 16'h0000);
    for (int i = 0; i < 8; i++) dbg_chk(i, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rel_ready", 16'(bus.instr_ready), 16'd1);

    // I-type sign extension: R1 = R1 + sext(0x84)
    push(16'h0000, 16'hFF84, 4'h2, 3'd1, 16'hFF84);
    send(16'h2384);
    #1;
    chk("i_n1_wb_valid", 16'(bus.wb_valid), 16'd0);
    @(negedge clk); #1;
    chk("i_n2_op_a", bus.op_a, 16'h0000);
    chk("i_n2_op_b", bus.op_b, 16'hFF84);
    chk("i_n2_func", 16'(bus.alu_func), 16'h2);
    chk("i_n2_wb_valid", 16'(bus.wb_valid), 16'd0);
    @(negedge clk); #1;
    chk("i_n3_wb_valid", 16'(bus.wb_valid), 16'd1);
    chk("i_n3_ready", 16'(bus.instr_ready), 16'd0);
    @(negedge clk); #1;
    chk("i_n4_ready", 16'(bus.instr_ready), 16'd1);
    chk("i_n4_wb_valid", 16'(bus.wb_valid), 16'd0);
    chk("i_n4_wb_data_hold", bus.wb_data, 16'hFF84);
    dbg_chk(1, 16'hFF84);

    // R-type: R2 = 1, then R2 = R2 + R1
    push(16'h0000, 16'h0001, 4'h2, 3'd2, 16'h0001);
    send(16'h2501);
    wait_idle();
    push(16'h0001, 16'hFF84, 4'h4, 3'd2, 16'hFF85);
    send(16'h4420);
    @(negedge clk); #1;
    chk("r_n2_op_a", bus.op_a, 16'h0001);
    chk("r_n2_op_b", bus.op_b, 16'hFF84);
    chk("r_n2_func", 16'(bus.alu_func), 16'h4);
    wait_idle();
    dbg_chk(2, 16'hFF85);

    // Back-to-back with valid held high
    w0 = wb_cnt;
    push(16'hFF84, 16'h0001, 4'h2, 3'd1, 16'hFF85);
    push(16'hFF85, 16'h0001, 4'h2, 3'd2, 16'hFF86);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = 16'h2301;
    #1;
    chk("b2b_ready_n", 16'(bus.instr_ready), 16'd1);
    @(negedge clk);
    bus.instr = 16'h2501;
    #1;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("b2b_gap1_%0d", k), 16'(bus.instr_ready), 16'd0);
      @(negedge clk); #1;
    end
    chk("b2b_ready_n4", 16'(bus.instr_ready), 16'd1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
    #1;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("b2b_gap2_%0d", k), 16'(bus.instr_ready), 16'd0);
      @(negedge clk); #1;
    end
    wait_idle();
    repeat (2) @(negedge clk);
    chk("b2b_wb_count", 16'(wb_cnt - w0), 16'd2);
    dbg_chk(1, 16'hFF85);
    dbg_chk(2, 16'hFF86);

    // NOP: no write-back, ready again at N+2
    w0 = wb_cnt;
    @(negedge clk);
    send(16'h0000);
    #1;
    chk("nop_n1_ready", 16'(bus.instr_ready), 16'd0);
    @(negedge clk); #1;
    chk("nop_n2_ready", 16'(bus.instr_ready), 16'd1);
    repeat (4) @(negedge clk);
    chk("nop_wb_count", 16'(wb_cnt - w0), 16'd0);

    // HALT: halted from N+2, ready stuck low, only rst recovers
    w0 = wb_cnt;
    send(16'hF000);
    #1;
    chk("halt_n1_halted", 16'(halted), 16'd0);
    @(negedge clk); #1;
    chk("halt_n2_halted", 16'(halted), 16'd1);
    bus.instr_valid = 1'b1;
    bus.instr = 16'h2301;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      chk("halt_ready", 16'(bus.instr_ready), 16'd0);
      chk("halt_halted", 16'(halted), 16'd1);
    end
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
    chk("halt_wb_count", 16'(wb_cnt - w0), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("halt_rst_halted", 16'(halted), 16'd0);
    chk("halt_rst_ready", 16'(bus.instr_ready), 16'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("halt_rel_ready", 16'(bus.instr_ready), 16'd1);
    dbg_chk(1, 16'h0000);
    dbg_chk(2, 16'h0000);

    // Reset during EXEC aborts the instruction
    w0 = wb_cnt;
    @(negedge clk);
    send(16'h2301);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("abort_wb_valid", 16'(bus.wb_valid), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("abort_ready", 16'(bus.instr_ready), 16'd1);
    dbg_chk(1, 16'h0000);
    repeat (4) @(negedge clk);
    chk("abort_wb_count", 16'(wb_cnt - w0), 16'd0);

    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
